// File: rtl/rns_dft_bin_if.sv
// rns_dft_bin_if: command/result bundle for the RNS single-bin DFT engine.
//   addr      - sample index for writes, bin index k for start
//   x         - signed sample to store
//   operation - 00 none, 01 write sample, 10 start bin, 11 reserved
//   y_re/y_im - packed residues, M0 channel in the low RW bits
//   busy      - bin computation in progress
//   done      - one-cycle pulse when y_re/y_im update
// master drives commands (host side), slave is the engine.
interface rns_dft_bin_if #(
  parameter int unsigned W  = 16,
  parameter int unsigned AW = 3,
  parameter int unsigned RW = 8
);
  logic [AW-1:0]       addr;
  logic signed [W-1:0] x;
  logic [1:0]          operation;
  logic [4*RW-1:0]     y_re;
  logic [4*RW-1:0]     y_im;
  logic                busy;
  logic                done;

  modport master (output addr, x, operation, input y_re, y_im, busy, done);
  modport slave  (input addr, x, operation, output y_re, y_im, busy, done);
endinterface

// File: rtl/rns_dft_bin.sv
// rns_dft_bin: single-bin N-point DFT accumulated in four RNS channels.
// Samples are written into a register buffer while idle; a start command
// walks n = 0..N-1 with twiddle index n*k mod N (by repeated addition),
// and each channel runs residue -> modular multiply -> modular accumulate.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-high
//   bus   - rns_dft_bin_if.slave (addr, x, operation in; y_re, y_im, busy, done out)
// Optional feature: define RNS_DFT_IM_EN to build the imaginary (-sin) path;
// without it y_im is constant zero and y_re timing is unchanged.
module rns_dft_bin #(
  parameter int unsigned N  = 8,
  parameter int unsigned W  = 16,
  parameter int unsigned Q  = 7,
  parameter int unsigned M0 = 233,
  parameter int unsigned M1 = 239,
  parameter int unsigned M2 = 241,
  parameter int unsigned M3 = 251,
  parameter int unsigned RW = 8
) (
  input logic          clk,
  input logic          reset,
  rns_dft_bin_if.slave bus
);
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned ModTab [4] = '{M0, M1, M2, M3};

  // Rounded (half away from zero) scaled twiddle: 2^Q*cos or -2^Q*sin.
  function automatic int tw_val(input int unsigned i, input bit is_sin);
    real ang;
    real v;
    ang = 2.0 * 3.14159265358979323846 * real'(i) / real'(N);
    v   = is_sin ? -$sin(ang) : $cos(ang);
    v   = v * (2.0 ** Q);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  function automatic logic [RW-1:0] to_res(input int t, input int unsigned m);
    int r;
    r = t % int'(m);
    if (r < 0) r = r + int'(m);
    return RW'(r);
  endfunction

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e              r_state;
  logic [AW-1:0]       r_n;
  logic [AW-1:0]       r_idx;
  logic [AW-1:0]       r_k;
  logic [1:0]          r_dcnt;
  logic                r_v1;
  logic                r_v2;
  logic                r_busy;
  logic                r_done;
  logic signed [W-1:0] r_mem [N];
  logic [4*RW-1:0]     r_y_re;
  logic [4*RW-1:0]     r_y_im;
  logic [4*RW-1:0]     w_acc_re;
  logic [4*RW-1:0]     w_acc_im;

  logic                w_start;
  logic                w_issue;
  logic                w_addr_ok;
  logic [AW:0]         w_addr_ext;
  logic [AW-1:0]       w_k;
  logic [AW:0]         w_idx_sum;
  logic [AW-1:0]       w_idx_nxt;
  logic [W-1:0]        w_sample;

  always_comb begin
    w_start    = (r_state == StIdle) && (bus.operation == 2'b10);
    w_issue    = (r_state == StRun);
    w_addr_ext = {1'b0, bus.addr};
    w_addr_ok  = (w_addr_ext < (AW+1)'(N));
    // addr < 2^AW < 2N, so one conditional subtract gives addr mod N
    w_k        = w_addr_ok ? bus.addr : AW'(w_addr_ext - (AW+1)'(N));
    w_idx_sum  = {1'b0, r_idx} + {1'b0, r_k};
    w_idx_nxt  = (w_idx_sum >= (AW+1)'(N)) ? AW'(w_idx_sum - (AW+1)'(N)) : AW'(w_idx_sum);
    w_sample   = r_mem[r_n];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_n     <= '0;
      r_idx   <= '0;
      r_k     <= '0;
      r_dcnt  <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_y_re  <= '0;
      r_y_im  <= '0;
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
    end else begin
      r_done <= 1'b0;
      r_v1   <= w_issue;
      r_v2   <= r_v1;
      unique case (r_state)
        StIdle: begin
          if (bus.operation == 2'b01 && w_addr_ok) begin
            r_mem[bus.addr] <= bus.x;
          end else if (bus.operation == 2'b10) begin
            r_k     <= w_k;
            r_n     <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_idx <= w_idx_nxt;
          if (r_n == AW'(N - 1)) begin
            r_n     <= '0;
            r_dcnt  <= '0;
            r_state <= StDrain;
          end else begin
            r_n <= r_n + AW'(1);
          end
        end
        StDrain: begin
          // two edges to flush stages 2/3, publish on the third
          if (r_dcnt == 2'd2) begin
            r_y_re  <= w_acc_re;
            r_y_im  <= w_acc_im;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_dcnt <= r_dcnt + 2'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_ch
    localparam int unsigned Mc  = ModTab[c];
    localparam logic [RW:0] McW = (RW+1)'(Mc);

    logic [RW-1:0] w_cos_rom [N];
    logic [W:0]    w_mag;
    logic [31:0]   w_mag_mod;
    logic [RW-1:0] w_xres;
    logic [RW:0]   w_sum_re;
    logic [RW-1:0] r_xr;
    logic [RW-1:0] r_tc;
    logic [RW-1:0] r_pc;
    logic [RW-1:0] r_acc_re;

    for (genvar i = 0; i < N; i++) begin : g_rom
      localparam logic [RW-1:0] CosRes = to_res(tw_val(i, 1'b0), Mc);
      assign w_cos_rom[i] = CosRes;
    end

    always_comb begin
      w_mag     = w_sample[W-1] ? ({1'b0, ~w_sample} + (W+1)'(1)) : {1'b0, w_sample};
      w_mag_mod = 32'(w_mag) % 32'(Mc);
      w_xres    = (w_sample[W-1] && (w_mag_mod != 32'd0)) ? RW'(32'(Mc) - w_mag_mod)
                                                          : RW'(w_mag_mod);
      w_sum_re  = {1'b0, r_acc_re} + {1'b0, r_pc};
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_xr     <= '0;
        r_tc     <= '0;
        r_pc     <= '0;
        r_acc_re <= '0;
      end else begin
        if (w_issue) begin
          r_xr <= w_xres;
          r_tc <= w_cos_rom[r_idx];
        end
        if (r_v1) r_pc <= RW'((32'(r_xr) * 32'(r_tc)) % 32'(Mc));
        if (w_start) r_acc_re <= '0;
        else if (r_v2) r_acc_re <= (w_sum_re >= McW) ? RW'(w_sum_re - McW) : RW'(w_sum_re);
      end
    end

    assign w_acc_re[c*RW +: RW] = r_acc_re;

`ifdef RNS_DFT_IM_EN
    logic [RW-1:0] w_sin_rom [N];
    logic [RW:0]   w_sum_im;
    logic [RW-1:0] r_ts;
    logic [RW-1:0] r_ps;
    logic [RW-1:0] r_acc_im;

    for (genvar i = 0; i < N; i++) begin : g_srom
      localparam logic [RW-1:0] SinRes = to_res(tw_val(i, 1'b1), Mc);
      assign w_sin_rom[i] = SinRes;
    end

    assign w_sum_im = {1'b0, r_acc_im} + {1'b0, r_ps};

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_ts     <= '0;
        r_ps     <= '0;
        r_acc_im <= '0;
      end else begin
        if (w_issue) r_ts <= w_sin_rom[r_idx];
        if (r_v1) r_ps <= RW'((32'(r_xr) * 32'(r_ts)) % 32'(Mc));
        if (w_start) r_acc_im <= '0;
        else if (r_v2) r_acc_im <= (w_sum_im >= McW) ? RW'(w_sum_im - McW) : RW'(w_sum_im);
      end
    end

    assign w_acc_im[c*RW +: RW] = r_acc_im;
`else
    assign w_acc_im[c*RW +: RW] = '0;
`endif
  end

  assign bus.y_re = r_y_re;
  assign bus.y_im = r_y_im;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_rns_dft_bin.sv
// tb_rns_dft_bin: directed bench for rns_dft_bin at default parameters.
// Expected residues go into a scoreboard queue when a bin is started and are
// compared when done pulses. Honours RNS_DFT_IM_EN for the y_im expectations.
module tb_rns_dft_bin;
  localparam int N = 8;

  logic clk;
  logic reset;

  rns_dft_bin_if #(.W(16), .AW(3), .RW(8)) bus ();

  rns_dft_bin dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] pack(input int a0, input int a1, input int a2, input int a3);
    return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int v);
    bus.operation = 2'b01;
    bus.addr      = 3'(a);
    bus.x         = 16'(v);
    @(posedge clk); #1;
    bus.operation = 2'b00;
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < N; i++) wr(i, v);
  endtask

  // Start bin k, wait for done, compare against the scoreboard head.
  // inject: during RUN try a sample write and a second start (both must be ignored).
  task automatic run_bin(input int k, input logic [31:0] e_re, input logic [31:0] e_im,
                         input bit inject, input string tag);
    exp_t e;
    int   edges;
    int   busy_cnt;
    bit   seen;
    exp_q.push_back('{re: e_re, im: e_im});
    bus.operation = 2'b10;
    bus.addr      = 3'(k);
    @(posedge clk); #1;
    bus.operation = 2'b00;
    edges    = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (!seen && edges < 40) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.busy) busy_cnt++;
        @(posedge clk); #1;
        edges++;
        if (inject) begin
          if (edges == 2) begin
            bus.operation = 2'b01; bus.addr = 3'd0; bus.x = 16'sd7;
          end else if (edges == 3) begin
            bus.operation = 2'b10; bus.addr = 3'd2;
          end else if (edges == 4) begin
            bus.operation = 2'b00;
          end
        end
      end
    end
    bus.operation = 2'b00;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(edges), 32'(N + 3));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(N + 3));
    e = exp_q.pop_front();
    check({tag, "_y_re"}, bus.y_re, e.re);
    check({tag, "_y_im"}, bus.y_im, e.im);
    check({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_y_re_hold"}, bus.y_re, e.re);
  endtask

  logic [31:0] im_x2;
  int          done_cnt;

  initial begin
`ifdef RNS_DFT_IM_EN
    im_x2 = pack(105, 111, 113, 123);
`else
    im_x2 = 32'd0;
`endif
    reset         = 1'b1;
    bus.operation = 2'b00;
    bus.addr      = '0;
    bus.x         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_y_re", bus.y_re, 32'd0);
    check("rst_y_im", bus.y_im, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Impulse x[0]=5, bin 3
    wr(0, 5);
    run_bin(3, pack(174, 162, 158, 138), 32'd0, 1'b0, "impulse_k3");

    // Constant ones
    fill(1);
    run_bin(0, pack(92, 68, 60, 20), 32'd0, 1'b0, "const_k0");
    run_bin(1, 32'd0, 32'd0, 1'b0, "const_k1");

    // Negative sample
    fill(0);
    wr(0, -1);
    run_bin(0, pack(105, 111, 113, 123), 32'd0, 1'b0, "neg_k0");

    // Imaginary path: x[2]=1, bin 1 -> twiddle index 2 (cos 0, -sin -128)
    wr(0, 0);
    wr(2, 1);
    run_bin(1, 32'd0, im_x2, 1'b0, "imag_k1");

    // Busy lockout: buffer holds only x[2]=1, so bin 0 gives 128 everywhere
    run_bin(0, pack(128, 128, 128, 128), 32'd0, 1'b1, "lockout_k0");
    run_bin(0, pack(128, 128, 128, 128), 32'd0, 1'b0, "lockout_buf");

    // Reset in the middle of a run
    wr(0, 5);
    bus.operation = 2'b10;
    bus.addr      = 3'd0;
    @(posedge clk); #1;
    bus.operation = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_y_re", bus.y_re, 32'd0);
    check("midrst_y_im", bus.y_im, 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    reset    = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    run_bin(0, 32'd0, 32'd0, 1'b0, "after_rst_k0");
    run_bin(1, 32'd0, 32'd0, 1'b0, "after_rst_k1");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
